// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG consumer: collector state encoding,
// word/result widths and the P-256 field prime used by rejection sampling.
package trng_pkg;

    localparam int WORD_W = 32;
    localparam int RND_W  = 256;
    localparam int WORDS  = RND_W / WORD_W;

    localparam logic [RND_W-1:0] P256 =
        256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        WAIT    = 3'd2,
        READ    = 3'd3,
        CAPTURE = 3'd4,
        CHECK   = 3'd5,
        DONE    = 3'd6
    } trng_col_state_t;

endpackage

// File: rtl/trng_lt_cmp.sv
// Combinational unsigned a < b comparator; the collector uses it to screen
// candidate values against the field prime when rejection sampling is built in.
module trng_lt_cmp #(
    parameter int W = 256
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt
);

    // Strict unsigned comparison, so a == b reports not-less-than.
    always_comb begin
        lt = 1'b0;
        if (a < b) begin
            lt = 1'b1;
        end else begin
            lt = 1'b0;
        end
    end

endmodule

// File: rtl/trng_collector.sv
// Collects eight TRNG words into one MSB-first 256-bit value and offers it on valid/ready.
// Optional feature macro TRNG_REJECT_EN: only deliver values strictly below P-256.
module trng_collector
    import trng_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    output logic              trng_en,
    output logic              trng_rd_en,
    output logic              trng_addr,
    input  logic [WORD_W-1:0] trng_out,
    input  logic              trng_rdy,
    output logic [RND_W-1:0]  rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              busy,
    output logic              err
);

    localparam int                CNT_W     = $clog2(WORDS);
    localparam int                TMO_W     = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX   = {TMO_W{1'b1}};

    trng_col_state_t    state_r;
    trng_col_state_t    state_s;
    logic               timeout_s;
    logic [CNT_W-1:0]   word_cnt_r;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic [RND_W-1:0]   acc_r;
    logic               trng_en_r;
    logic               trng_rd_en_r;
    logic               rnd_valid_r;
    logic               busy_r;
    logic               err_r;

`ifdef TRNG_REJECT_EN
    logic               lt_s;
    logic [15:0]        rej_cnt_r;

    trng_lt_cmp #(.W(RND_W)) u_lt_cmp (
        .a  (acc_r),
        .b  (P256),
        .lt (lt_s)
    );

    // Count discarded candidates, saturating at the top of the 16-bit range.
    always_ff @(posedge clk) begin
        if (rst) begin
            rej_cnt_r <= 16'd0;
        end else if ((state_r == CHECK) && !lt_s && (rej_cnt_r != 16'hFFFF)) begin
            rej_cnt_r <= rej_cnt_r + 16'd1;
        end else begin
            rej_cnt_r <= rej_cnt_r;
        end
    end
`endif

    // Next-state decode; the first WAIT cycle ignores rdy because the TRNG drops it one cycle late.
    always_comb begin
        state_s   = state_r;
        timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req && trng_rdy) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START:   state_s = WAIT;
            WAIT: begin
                if ((tmo_cnt_r != {TMO_W{1'b0}}) && trng_rdy) begin
                    state_s = READ;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    state_s   = IDLE;
                    timeout_s = 1'b1;
                end else begin
                    state_s = WAIT;
                end
            end
            READ:    state_s = CAPTURE;
            CAPTURE: begin
                if (word_cnt_r == LAST_WORD) begin
                    state_s = CHECK;
                end else begin
                    state_s = START;
                end
            end
            CHECK: begin
`ifdef TRNG_REJECT_EN
                if (lt_s) begin
                    state_s = DONE;
                end else begin
                    state_s = START;
                end
`else
                state_s = DONE;
`endif
            end
            DONE: begin
                if (rnd_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, counters, accumulator and outputs decoded from the next state so pins stay registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            word_cnt_r   <= {CNT_W{1'b0}};
            tmo_cnt_r    <= {TMO_W{1'b0}};
            acc_r        <= {RND_W{1'b0}};
            trng_en_r    <= 1'b0;
            trng_rd_en_r <= 1'b0;
            rnd_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            trng_en_r    <= (state_s == START);
            trng_rd_en_r <= (state_s == READ);
            rnd_valid_r  <= (state_s == DONE);
            busy_r       <= (state_s != IDLE);
            err_r        <= timeout_s;

            if (state_r == START) begin
                tmo_cnt_r <= {TMO_W{1'b0}};
            end else if ((state_r == WAIT) && (tmo_cnt_r != TMO_MAX)) begin
                tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end

            // An aborted collection must not leave a partial word count behind.
            if (timeout_s) begin
                word_cnt_r <= {CNT_W{1'b0}};
            end else if (state_r == CAPTURE) begin
                if (word_cnt_r == LAST_WORD) begin
                    word_cnt_r <= {CNT_W{1'b0}};
                end else begin
                    word_cnt_r <= word_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                word_cnt_r <= word_cnt_r;
            end

            if (state_r == CAPTURE) begin
                acc_r <= {acc_r[RND_W-WORD_W-1:0], trng_out};
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    assign trng_en    = trng_en_r;
    assign trng_rd_en = trng_rd_en_r;
    assign trng_addr  = 1'b0;
    assign rnd_data   = acc_r;
    assign rnd_valid  = rnd_valid_r;
    assign busy       = busy_r;
    assign err        = err_r;

endmodule

// File: tb/tb_trng_collector.sv
// Directed bench for trng_collector with a small behavioural TRNG model on the falling edge.
module tb_trng_collector;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic         trng_en;
    logic         trng_rd_en;
    logic         trng_addr;
    logic [31:0]  trng_out;
    logic         trng_rdy;
    logic [255:0] rnd_data;
    logic         rnd_valid;
    logic         rnd_ready;
    logic         busy;
    logic         err;

    int           checks   = 0;
    int           failures = 0;

    logic [31:0]  words [16];
    int           idx;
    int           en_cnt;
    int           overlap_cnt;
    logic         stuck;
    int           cyc;

    trng_collector dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .trng_en    (trng_en),
        .trng_rd_en (trng_rd_en),
        .trng_addr  (trng_addr),
        .trng_out   (trng_out),
        .trng_rdy   (trng_rdy),
        .rnd_data   (rnd_data),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // TRNG model: rdy low for two falling edges after en, data only in the cycle after rd_en.
    initial begin
        int   cnt;
        logic prev_rd;
        cnt      = 0;
        prev_rd  = 1'b0;
        trng_rdy = 1'b1;
        trng_out = 32'h0BAD0BAD;
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt      = 0;
                prev_rd  = 1'b0;
                trng_rdy = 1'b1;
                trng_out = 32'h0BAD0BAD;
            end else begin
                if (trng_en) en_cnt++;
                if (trng_en && trng_rd_en) overlap_cnt++;
                if (prev_rd && (idx < 16)) begin
                    trng_out = words[idx];
                    idx++;
                end else begin
                    trng_out = 32'h0BAD0BAD;
                end
                prev_rd = trng_rd_en;
                if (trng_en) begin
                    trng_rdy = 1'b0;
                    cnt      = 2;
                end else if (cnt > 1) begin
                    cnt--;
                end else begin
                    cnt = 0;
                    if (!stuck) trng_rdy = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present req for one acceptance edge, then count edges until valid, err or the budget runs out.
    task automatic run_req(input int limit, output int n);
        req = 1'b1;
        tick();
        req = 1'b0;
        n   = 0;
        while (!rnd_valid && !err && (n < limit)) begin
            tick();
            n++;
        end
    endtask

    task automatic handshake();
        rnd_ready = 1'b1;
        tick();
        rnd_ready = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        req         = 1'b1;
        rnd_ready   = 1'b0;
        stuck       = 1'b0;
        idx         = 0;
        en_cnt      = 0;
        overlap_cnt = 0;
        for (int i = 0; i < 16; i++) words[i] = 32'h0;

        // 1: reset held three cycles with req high
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_trng_en",   256'(trng_en),    256'(1'b0));
            check("rst_trng_rd",   256'(trng_rd_en), 256'(1'b0));
            check("rst_busy",      256'(busy),       256'(1'b0));
            check("rst_valid",     256'(rnd_valid),  256'(1'b0));
            check("rst_err",       256'(err),        256'(1'b0));
            check("rst_data",      rnd_data,         256'h0);
        end
        req = 1'b0;
        rst = 1'b0;
        tick();
        check("idle_busy", 256'(busy), 256'(1'b0));

        // 2: words 1..8, rdy back after two cycles
        for (int i = 0; i < 8; i++) words[i] = 32'(i + 1);
        idx    = 0;
        en_cnt = 0;
        run_req(100, cyc);
        check("t2_valid",   256'(rnd_valid), 256'(1'b1));
        check("t2_latency", 256'(cyc),       256'(41));
        check("t2_data",    rnd_data,
              256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008);
        check("t2_en_cnt",  256'(en_cnt),    256'(8));
        check("t2_busy",    256'(busy),      256'(1'b1));
        check("t2_addr",    256'(trng_addr), 256'(1'b0));

        // 3: back-pressure with req held high, then accept
        req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_hold_valid", 256'(rnd_valid), 256'(1'b1));
            check("t3_hold_data",  rnd_data,
                  256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008);
            check("t3_no_en",      256'(trng_en),   256'(1'b0));
        end
        req = 1'b0;
        handshake();
        check("t3_valid_clr", 256'(rnd_valid), 256'(1'b0));
        check("t3_busy_clr",  256'(busy),      256'(1'b0));
        check("t3_en_total",  256'(en_cnt),    256'(8));

        // 4: TRNG never comes back after en
        stuck  = 1'b1;
        en_cnt = 0;
        run_req(1100, cyc);
        check("t4_err",      256'(err),       256'(1'b1));
        check("t4_err_time", 256'(cyc),       256'(1025));
        check("t4_busy",     256'(busy),      256'(1'b0));
        check("t4_valid",    256'(rnd_valid), 256'(1'b0));
        tick();
        check("t4_err_pulse", 256'(err),      256'(1'b0));
        check("t4_en_cnt",    256'(en_cnt),   256'(1));
        stuck = 1'b0;
        tick();
        tick();

        // 5: all-ones candidate first, then zero
`ifdef TRNG_REJECT_EN
        for (int i = 0; i < 8; i++) words[i] = 32'hFFFFFFFF;
        for (int i = 8; i < 16; i++) words[i] = 32'h0;
        idx    = 0;
        en_cnt = 0;
        run_req(200, cyc);
        check("t5_valid",   256'(rnd_valid), 256'(1'b1));
        check("t5_data",    rnd_data,        256'h0);
        check("t5_en_cnt",  256'(en_cnt),    256'(16));
        check("t5_latency", 256'(cyc),       256'(82));
`else
        for (int i = 0; i < 8; i++) words[i] = 32'hFFFFFFFF;
        idx    = 0;
        en_cnt = 0;
        run_req(200, cyc);
        check("t5_valid",   256'(rnd_valid), 256'(1'b1));
        check("t5_data",    rnd_data,        {8{32'hFFFFFFFF}});
        check("t5_en_cnt",  256'(en_cnt),    256'(8));
        check("t5_latency", 256'(cyc),       256'(41));
`endif
        handshake();
        check("t5_idle", 256'(busy), 256'(1'b0));

        // 6: reset in the middle of a collection, then a clean run
        for (int i = 0; i < 8; i++) words[i] = 32'hA0000000 + 32'(i);
        idx = 0;
        req = 1'b1;
        tick();
        req = 1'b0;
        cyc = 0;
        while ((idx < 4) && (cyc < 100)) begin
            tick();
            cyc++;
        end
        check("t6_reached_w4", 256'(idx), 256'(4));
        rst = 1'b1;
        tick();
        check("t6_rst_busy",  256'(busy),    256'(1'b0));
        check("t6_rst_en",    256'(trng_en), 256'(1'b0));
        check("t6_rst_rd",    256'(trng_rd_en), 256'(1'b0));
        check("t6_rst_data",  rnd_data,      256'h0);
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) words[i] = 32'hC0DE0001 + 32'(i);
        idx    = 0;
        en_cnt = 0;
        run_req(100, cyc);
        check("t6_valid",   256'(rnd_valid), 256'(1'b1));
        check("t6_latency", 256'(cyc),       256'(41));
        check("t6_data",    rnd_data,
              256'hC0DE0001_C0DE0002_C0DE0003_C0DE0004_C0DE0005_C0DE0006_C0DE0007_C0DE0008);
        check("t6_en_cnt",  256'(en_cnt),    256'(8));
        handshake();
        check("t6_idle",    256'(busy),      256'(1'b0));

        check("en_rd_overlap", 256'(overlap_cnt), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
